// File: rtl/ee357_mcpu_pkg.sv
// Shared definitions for the multicycle-CPU memory arbiter.
package ee357_mcpu_pkg;

  localparam int unsigned DW                    = 32;
  localparam int unsigned MAX_DMA_BURST_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CPU_ACC = 2'b01,
    DMA_ACC = 2'b10
  } arb_state_e;

endpackage

// File: rtl/ee357_mcpu_mem_arb.sv
// Single-port memory arbiter between the multicycle CPU and a loader/DMA.
// DMA wins in IDLE until it has taken MAX_DMA_BURST grants in a row while
// the CPU waits; then the CPU gets one access. Transfers are never preempted.
module ee357_mcpu_mem_arb
  import ee357_mcpu_pkg::*;
#(
  parameter int unsigned MAX_DMA_BURST = MAX_DMA_BURST_DEFAULT,
  parameter int unsigned AW            = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int unsigned    BW        = $clog2(MAX_DMA_BURST + 1);
  localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_DMA_BURST);

  arb_state_e     state_q;
  logic [BW-1:0]  burst_q, burst_d;
  logic           mem_en_q, mem_we_q, dma_done_q;
  logic [AW-1:0]  mem_addr_q;
  logic [DW-1:0]  mem_wdata_q, cpu_rdata_q, dma_rdata_q;

  logic           cpu_pend, dma_grant, cpu_grant;
  logic           unused_addr_lsbs;

  // Word alignment drops the byte-offset bits of both requesters.
  assign unused_addr_lsbs = ^{cpu_addr[1:0], dma_addr[1:0]};

  // Grant decisions, CPU stall and next burst count.
  always_comb begin
    cpu_pend  = cpu_rd | cpu_wr;
    dma_grant = (state_q == IDLE) && dma_req && (burst_q < BURST_MAX);
    cpu_grant = (state_q == IDLE) && !dma_grant && cpu_pend;
    cpu_stall = cpu_pend & ~((state_q == CPU_ACC) & mem_ready);
    burst_d   = burst_q;
    if (!cpu_pend || cpu_grant) begin
      burst_d = '0;
    end else if (dma_grant) begin
      burst_d = burst_q + 1'b1;
    end
  end

  // Arbiter FSM: latch the granted request, hold the strobe until mem_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      dma_done_q  <= 1'b0;
    end else begin
      dma_done_q <= 1'b0;
      burst_q    <= burst_d;
      case (state_q)
        IDLE: begin
          if (dma_grant) begin
            state_q     <= DMA_ACC;
            mem_en_q    <= 1'b1;
            mem_we_q    <= dma_we;
            mem_addr_q  <= {dma_addr[AW-1:2], 2'b00};
            mem_wdata_q <= dma_wdata;
          end else if (cpu_grant) begin
            state_q     <= CPU_ACC;
            mem_en_q    <= 1'b1;
            mem_we_q    <= cpu_wr;
            mem_addr_q  <= {cpu_addr[AW-1:2], 2'b00};
            mem_wdata_q <= cpu_wdata;
          end
        end
        CPU_ACC: begin
          if (mem_ready) begin
            if (!mem_we_q) cpu_rdata_q <= mem_rdata;
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
          end
        end
        DMA_ACC: begin
          if (mem_ready) begin
            if (!mem_we_q) dma_rdata_q <= mem_rdata;
            dma_done_q <= 1'b1;
            state_q    <= IDLE;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_done  = dma_done_q;

endmodule

// File: tb/tb_ee357_mcpu_mem_arb.sv
// Bench for ee357_mcpu_mem_arb: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a transaction-level model.
module tb_ee357_mcpu_mem_arb;

  localparam int unsigned MAXB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr, dma_req, dma_we, mem_ready;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_stall, dma_done, mem_en, mem_we;

  int passed = 0;
  int total  = 0;

  ee357_mcpu_mem_arb #(.MAX_DMA_BURST(MAXB), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rd, wr; logic [31:0] addr, wdata;
    logic dreq, dwe; logic [31:0] daddr, dwdata;
    logic rdy; logic [31:0] rdata;
    logic e_stall, e_en, e_we; logic [31:0] e_addr, e_wdata;
    logic e_done; logic [31:0] e_crd, e_drd;
  } vec_t;

  function automatic vec_t row(
    logic rd, logic wr, logic [31:0] a, logic [31:0] wd,
    logic dr, logic dw, logic [31:0] da, logic [31:0] dwd,
    logic rdy, logic [31:0] rdt,
    logic es, logic een, logic ewe, logic [31:0] ea, logic [31:0] ewd,
    logic edn, logic [31:0] ecr, logic [31:0] edr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
    v.dreq = dr; v.dwe = dw; v.daddr = da; v.dwdata = dwd;
    v.rdy = rdy; v.rdata = rdt;
    v.e_stall = es; v.e_en = een; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ewd;
    v.e_done = edn; v.e_crd = ecr; v.e_drd = edr;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    bit          busy;
    bit          is_dma;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       cur;
  int unsigned dma_streak;   // DMA grants taken in a row while the CPU waited
  logic [31:0] m_crd, m_drd;
  bit          m_done;

  function automatic void model_reset();
    cur = '{busy: 0, is_dma: 0, we: 0, addr: '0, wdata: '0};
    dma_streak = 0; m_crd = '0; m_drd = '0; m_done = 0;
  endfunction

  function automatic void model_step();
    bit cpu_want = cpu_rd | cpu_wr;
    bit done_n = 0;
    if (!cur.busy) begin
      if (dma_req && dma_streak < MAXB) begin
        cur = '{busy: 1, is_dma: 1, we: dma_we, addr: dma_addr & ~32'h3, wdata: dma_wdata};
        dma_streak = cpu_want ? dma_streak + 1 : 0;
      end else if (cpu_want) begin
        cur = '{busy: 1, is_dma: 0, we: cpu_wr, addr: cpu_addr & ~32'h3, wdata: cpu_wdata};
        dma_streak = 0;
      end else begin
        dma_streak = 0;
      end
    end else begin
      if (!cpu_want) dma_streak = 0;
      if (mem_ready) begin
        if (!cur.we) begin
          if (cur.is_dma) m_drd = mem_rdata;
          else            m_crd = mem_rdata;
        end
        done_n = cur.is_dma;
        cur.busy = 0;
      end
    end
    m_done = done_n;
  endfunction

  vec_t tbl[13];
  int   ng, dones;
  bit   cpu_seen;
  int   order[6];
  int   exp_order[6];
  bit   exp_stall;

  initial begin
    // rd, wr, addr, wdata | dreq, dwe, daddr, dwdata | rdy, rdata || stall, en, we, addr, wdata, done, cpu_rdata, dma_rdata
    tbl[0]  = row(1,0,32'h10,0,                0,0,0,0,                     0,0,             1,0,0,0,0,0,32'h0,0);
    tbl[1]  = row(1,0,32'h10,0,                0,0,0,0,                     1,32'h8C220004,  0,1,0,32'h10,0,0,32'h0,0);
    tbl[2]  = row(0,1,32'h103,32'hDEADBEEF,    0,0,0,0,                     0,0,             1,0,0,0,0,0,32'h8C220004,0);
    tbl[3]  = row(0,1,32'h103,32'hDEADBEEF,    0,0,0,0,                     0,0,             1,1,1,32'h100,32'hDEADBEEF,0,32'h8C220004,0);
    tbl[4]  = row(0,1,32'h103,32'hDEADBEEF,    0,0,0,0,                     1,32'h12345678,  0,1,1,32'h100,32'hDEADBEEF,0,32'h8C220004,0);
    tbl[5]  = row(0,0,0,0,                     1,0,32'h207,0,               1,32'hAAAA5555,  0,0,0,0,0,0,32'h8C220004,0);
    tbl[6]  = row(0,0,0,0,                     0,0,0,0,                     1,32'hCAFEF00D,  0,1,0,32'h204,0,0,32'h8C220004,0);
    tbl[7]  = row(0,0,0,0,                     0,0,0,0,                     0,0,             0,0,0,0,0,1,32'h8C220004,32'hCAFEF00D);
    tbl[8]  = row(1,0,32'h40,0,                1,1,32'h300,32'h01020304,    0,0,             1,0,0,0,0,0,32'h8C220004,32'hCAFEF00D);
    tbl[9]  = row(1,0,32'h40,0,                1,1,32'h300,32'h01020304,    1,32'hFFFFFFFF,  1,1,1,32'h300,32'h01020304,0,32'h8C220004,32'hCAFEF00D);
    tbl[10] = row(1,0,32'h40,0,                0,0,0,0,                     0,0,             1,0,0,0,0,1,32'h8C220004,32'hCAFEF00D);
    tbl[11] = row(1,0,32'h40,0,                0,0,0,0,                     1,32'h0BADC0DE,  0,1,0,32'h40,0,0,32'h8C220004,32'hCAFEF00D);
    tbl[12] = row(0,0,0,0,                     0,0,0,0,                     0,0,             0,0,0,0,0,0,32'h0BADC0DE,32'hCAFEF00D);
    exp_order = '{1, 1, 1, 1, 0, 1};

    // ---- reset state ----
    rst = 1'b0;
    idle_inputs();
    cpu_rd = 1;
    tick(); tick();
    chk("rst_stall_with_req", cpu_stall, 1);
    cpu_rd = 0;
    #1;
    chk("rst_stall_no_req", cpu_stall, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    chk("rst_dma_done", dma_done, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // ---- vector table ----
    for (int i = 0; i < 13; i++) begin
      cpu_rd = tbl[i].rd; cpu_wr = tbl[i].wr; cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata;
      dma_req = tbl[i].dreq; dma_we = tbl[i].dwe; dma_addr = tbl[i].daddr; dma_wdata = tbl[i].dwdata;
      mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), cpu_stall, tbl[i].e_stall);
      chk($sformatf("vec%0d_en", i), mem_en, tbl[i].e_en);
      chk($sformatf("vec%0d_we", i), mem_we, tbl[i].e_we);
      chk($sformatf("vec%0d_done", i), dma_done, tbl[i].e_done);
      chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, tbl[i].e_crd);
      chk($sformatf("vec%0d_dma_rdata", i), dma_rdata, tbl[i].e_drd);
      if (tbl[i].e_en) chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].e_addr);
      if (tbl[i].e_we) chk($sformatf("vec%0d_wdata", i), mem_wdata, tbl[i].e_wdata);
      tick();
    end

    // ---- DMA burst limit with CPU waiting ----
    idle_inputs();
    cpu_rd = 1; cpu_addr = 32'h80; dma_req = 1; dma_addr = 32'h900;
    mem_ready = 1; mem_rdata = 32'h5A5A0000;
    ng = 0; dones = 0; cpu_seen = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      @(negedge clk);
      if (dma_done && !cpu_seen) dones++;
      if (mem_en) begin
        order[ng] = (mem_addr == 32'h900) ? 1 : 0;
        if (mem_addr == 32'h80) begin
          cpu_seen = 1;
          chk("burst_cpu_stall_release", cpu_stall, 0);
        end
        ng++;
      end
      if (ng < 6) tick();
    end
    chk("burst_grant_count", ng, 6);
    for (int k = 0; k < 6; k++)
      if (k < ng) chk($sformatf("burst_grant%0d_is_dma", k), order[k], exp_order[k]);
    chk("burst_dones_before_cpu", dones, 4);
    cpu_rd = 0; dma_req = 0;
    tick(); tick();

    // ---- long wait state, DMA raised mid-access ----
    idle_inputs();
    cpu_rd = 1; cpu_addr = 32'h444;
    @(negedge clk);
    chk("wait_idle_en", mem_en, 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin dma_req = 1; dma_addr = 32'h500; end
      @(negedge clk);
      chk($sformatf("wait%0d_en", c), mem_en, 1);
      chk($sformatf("wait%0d_stall", c), cpu_stall, 1);
      chk($sformatf("wait%0d_addr", c), mem_addr, 32'h444);
      tick();
    end
    mem_ready = 1; mem_rdata = 32'h600DF00D;
    @(negedge clk);
    chk("wait_ready_en", mem_en, 1);
    chk("wait_ready_stall", cpu_stall, 0);
    tick();
    cpu_rd = 0; mem_ready = 0;
    @(negedge clk);
    chk("wait_after_en", mem_en, 0);
    chk("wait_after_cpu_rdata", cpu_rdata, 32'h600DF00D);
    tick();
    @(negedge clk);
    chk("wait_dma_served_en", mem_en, 1);
    chk("wait_dma_served_addr", mem_addr, 32'h500);
    mem_ready = 1; mem_rdata = 32'h11112222; dma_req = 0;
    tick();
    @(negedge clk);
    chk("wait_dma_done", dma_done, 1);
    chk("wait_dma_rdata", dma_rdata, 32'h11112222);
    tick();

    // ---- reset in the middle of a DMA access ----
    idle_inputs();
    dma_req = 1; dma_addr = 32'h700;
    tick();
    @(negedge clk);
    chk("abort_pre_en", mem_en, 1);
    #2;
    cpu_rd = 1; rst = 1'b0;
    #1;
    chk("abort_en", mem_en, 0);
    chk("abort_done", dma_done, 0);
    chk("abort_dma_rdata", dma_rdata, 0);
    chk("abort_stall_in_reset", cpu_stall, 1);
    @(posedge clk);
    #1;
    chk("abort_done_held", dma_done, 0);
    @(negedge clk);
    rst = 1'b1; cpu_rd = 0;
    #1;
    chk("abort_no_early_grant", mem_en, 0);
    tick();
    chk("abort_regrant_en", mem_en, 1);
    chk("abort_regrant_addr", mem_addr, 32'h700);
    mem_ready = 1; dma_req = 0;
    tick(); tick();

    // ---- randomized traffic vs. model ----
    idle_inputs();
    rst = 1'b0;
    #1;
    model_reset();
    tick();
    rst = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (n < 200) cpu_rd = ($urandom % 8) != 0;
      else         cpu_rd = ($urandom % 3) == 0;
      cpu_wr    = ($urandom % 4) == 0;
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      dma_req   = ($urandom % 2) == 0;
      dma_we    = ($urandom % 2) == 0;
      dma_addr  = $urandom;
      dma_wdata = $urandom;
      mem_ready = ($urandom % 3) != 0;
      mem_rdata = $urandom;
      @(negedge clk);
      exp_stall = (cpu_rd | cpu_wr) && !(cur.busy && !cur.is_dma && mem_ready);
      chk("rnd_en", mem_en, cur.busy);
      chk("rnd_we", mem_we, cur.busy & cur.we);
      chk("rnd_stall", cpu_stall, exp_stall);
      chk("rnd_done", dma_done, m_done);
      chk("rnd_cpu_rdata", cpu_rdata, m_crd);
      chk("rnd_dma_rdata", dma_rdata, m_drd);
      if (cur.busy) chk("rnd_addr", mem_addr, cur.addr);
      if (cur.busy && cur.we) chk("rnd_wdata", mem_wdata, cur.wdata);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
